// File: rtl/multi_debouncer.sv
`timescale 1ns/1ps
// multi_debouncer
//   Per-channel switch debouncer. Each raw input is brought into the CLK
//   domain through a two-flop synchronizer and then filtered by a small
//   IDLE/CHK state machine: a new level is accepted only after MIN_LEN
//   consecutive synchronized samples disagree with the current level.
//   Accepted changes update LEVEL and emit a single-cycle RISE or FALL pulse.
//
// Parameters
//   N_CH     number of independent channels (1..32)
//   MIN_LEN  consecutive differing samples needed to accept a change (2..255)
//   INIT_LVL debounced level of every channel after reset
//
// Ports
//   CLK    clock, all state changes on the rising edge
//   RST    asynchronous active-high reset
//   I      raw bouncing inputs, one bit per channel
//   EN     global filter enable; low discards any check in progress
//   LEVEL  registered debounced level per channel
//   RISE   one-cycle pulse when LEVEL[k] goes 0->1
//   FALL   one-cycle pulse when LEVEL[k] goes 1->0
//   BUSY   high while any channel is checking a candidate change
module multi_debouncer #(
  parameter int unsigned N_CH     = 4,
  parameter int unsigned MIN_LEN  = 8,
  parameter logic        INIT_LVL = 1'b0
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic [N_CH-1:0] I,
  input  logic            EN,
  output logic [N_CH-1:0] LEVEL,
  output logic [N_CH-1:0] RISE,
  output logic [N_CH-1:0] FALL,
  output logic            BUSY
);

  typedef enum logic {
    ST_IDLE,
    ST_CHK
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(MIN_LEN - 1);

  logic [N_CH-1:0] sync1_q;
  logic [N_CH-1:0] sync2_q;

  state_t          state_q [N_CH];
  state_t          state_d [N_CH];
  logic [7:0]      cnt_q   [N_CH];
  logic [7:0]      cnt_d   [N_CH];

  logic [N_CH-1:0] level_q, level_d;
  logic [N_CH-1:0] rise_q,  rise_d;
  logic [N_CH-1:0] fall_q,  fall_d;
  logic            busy_q,  busy_d;

  // Synchronizer runs independently of EN so the sampled value is always fresh.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync1_q <= {N_CH{INIT_LVL}};
      sync2_q <= {N_CH{INIT_LVL}};
    end else begin
      sync1_q <= I;
      sync2_q <= sync1_q;
    end
  end

  // Every path that does not explicitly stay in CHK lands in IDLE with CNT=0,
  // which covers EN=0, glitch rejection and the acceptance cycle alike.
  always_comb begin
    level_d = level_q;
    rise_d  = '0;
    fall_d  = '0;
    busy_d  = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      state_d[k] = ST_IDLE;
      cnt_d[k]   = '0;
      if (EN && (sync2_q[k] != level_q[k])) begin
        case (state_q[k])
          ST_IDLE: begin
            state_d[k] = ST_CHK;
            cnt_d[k]   = 8'd1;
          end
          ST_CHK: begin
            if (cnt_q[k] == CNT_LAST) begin
              level_d[k] = ~level_q[k];
              rise_d[k]  = ~level_q[k];
              fall_d[k]  = level_q[k];
            end else begin
              state_d[k] = ST_CHK;
              cnt_d[k]   = cnt_q[k] + 8'd1;
            end
          end
          default: begin
            state_d[k] = ST_IDLE;
            cnt_d[k]   = '0;
          end
        endcase
      end
      // Registered from next-state so BUSY lines up with the CHK cycles.
      busy_d = busy_d | (state_d[k] == ST_CHK);
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        state_q[k] <= ST_IDLE;
        cnt_q[k]   <= '0;
      end
      level_q <= {N_CH{INIT_LVL}};
      rise_q  <= '0;
      fall_q  <= '0;
      busy_q  <= 1'b0;
    end else begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign LEVEL = level_q;
  assign RISE  = rise_q;
  assign FALL  = fall_q;
  assign BUSY  = busy_q;

endmodule

// File: tb/tb_multi_debouncer.sv
`timescale 1ns/1ps
// Self-checking bench for multi_debouncer. Two instances share I and EN:
// u0 with INIT_LVL=0 and u1 with INIT_LVL=1, each with its own reset.
module tb_multi_debouncer;

  localparam int N  = 4;
  localparam int ML = 8;

  logic         clk  = 1'b0;
  logic         rst0 = 1'b1;
  logic         rst1 = 1'b1;
  logic         en   = 1'b1;
  logic [N-1:0] din  = '0;

  logic [N-1:0] lvl0, rise0, fall0, lvl1, rise1, fall1;
  logic         busy0, busy1;

  always #5 clk = ~clk;

  multi_debouncer #(.N_CH(N), .MIN_LEN(ML), .INIT_LVL(1'b0)) u0 (
    .CLK(clk), .RST(rst0), .I(din), .EN(en),
    .LEVEL(lvl0), .RISE(rise0), .FALL(fall0), .BUSY(busy0)
  );

  multi_debouncer #(.N_CH(N), .MIN_LEN(ML), .INIT_LVL(1'b1)) u1 (
    .CLK(clk), .RST(rst1), .I(din), .EN(en),
    .LEVEL(lvl1), .RISE(rise1), .FALL(fall1), .BUSY(busy1)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: the filtered input is the raw input seen two edges
  // earlier; a level is accepted once ML consecutive edges (with EN high)
  // see that filtered input differ from the current level.
  logic [N-1:0] m_d1 [2];
  logic [N-1:0] m_d2 [2];
  logic [N-1:0] m_lvl [2];
  logic [N-1:0] m_rise [2];
  logic [N-1:0] m_fall [2];
  logic         m_busy [2];
  int           m_run [2][N];

  task automatic m_reset(input int u, input logic init);
    m_d1[u]   = {N{init}};
    m_d2[u]   = {N{init}};
    m_lvl[u]  = {N{init}};
    m_rise[u] = '0;
    m_fall[u] = '0;
    m_busy[u] = 1'b0;
    for (int k = 0; k < N; k++) m_run[u][k] = 0;
  endtask

  task automatic m_step(input int u);
    logic s;
    for (int k = 0; k < N; k++) begin
      s = m_d2[u][k];
      m_rise[u][k] = 1'b0;
      m_fall[u][k] = 1'b0;
      if (en && (s !== m_lvl[u][k])) begin
        m_run[u][k] = m_run[u][k] + 1;
        if (m_run[u][k] == ML) begin
          m_lvl[u][k] = s;
          if (s) m_rise[u][k] = 1'b1;
          else   m_fall[u][k] = 1'b1;
          m_run[u][k] = 0;
        end
      end else begin
        m_run[u][k] = 0;
      end
    end
    m_d2[u] = m_d1[u];
    m_d1[u] = din;
    m_busy[u] = 1'b0;
    for (int k = 0; k < N; k++) if (m_run[u][k] > 0) m_busy[u] = 1'b1;
  endtask

  always @(posedge clk or posedge rst0) begin
    if (rst0) m_reset(0, 1'b0);
    else      m_step(0);
  end

  always @(posedge clk or posedge rst1) begin
    if (rst1) m_reset(1, 1'b1);
    else      m_step(1);
  end

  // Per-cycle comparison against the model plus the pulse-shape rules.
  logic         chk_on = 1'b0;
  logic [N-1:0] prev0  = '0;
  logic [N-1:0] prev1  = '0;

  always @(negedge clk) begin
    if (chk_on) begin
      chk("u0_level", 32'(lvl0),  32'(m_lvl[0]));
      chk("u0_rise",  32'(rise0), 32'(m_rise[0]));
      chk("u0_fall",  32'(fall0), 32'(m_fall[0]));
      chk("u0_busy",  32'(busy0), 32'(m_busy[0]));
      chk("u1_level", 32'(lvl1),  32'(m_lvl[1]));
      chk("u1_rise",  32'(rise1), 32'(m_rise[1]));
      chk("u1_fall",  32'(fall1), 32'(m_fall[1]));
      chk("u1_busy",  32'(busy1), 32'(m_busy[1]));
      chk("u0_pulse_rule", 32'((rise0 & fall0) | (prev0 & (rise0 | fall0))), 32'd0);
      chk("u1_pulse_rule", 32'((rise1 & fall1) | (prev1 & (rise1 | fall1))), 32'd0);
      prev0 = rise0 | fall0;
      prev1 = rise1 | fall1;
    end
  end

  int rises;
  int at;
  logic rst_hold;

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk_on = 1'b1;
    chk("rst_u0_level", 32'(lvl0), 32'h0);
    chk("rst_u1_level", 32'(lvl1), 32'hF);
    chk("rst_u0_busy",  32'(busy0), 32'h0);
    chk("rst_u0_pulses", 32'(rise0 | fall0), 32'h0);
    #2 rst0 = 1'b0; rst1 = 1'b0;
    repeat (4) @(negedge clk);

    // Single rising edge on channel 0: accepted ML+1 edges after the first sample edge
    din[0] = 1'b1;
    repeat (ML + 1) @(negedge clk);
    chk("lat_before_level", 32'(lvl0), 32'h0);
    chk("lat_before_rise",  32'(rise0), 32'h0);
    @(negedge clk);
    chk("lat_level", 32'(lvl0), 32'h1);
    chk("lat_rise",  32'(rise0), 32'h1);
    @(negedge clk);
    chk("lat_rise_gone", 32'(rise0), 32'h0);
    chk("lat_level_hold", 32'(lvl0), 32'h1);

    // 7-cycle glitch on channel 1 is rejected
    din[1] = 1'b1;
    repeat (4) @(negedge clk);
    chk("glitch_busy", 32'(busy0), 32'h1);
    repeat (3) @(negedge clk);
    din[1] = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_busy_low", 32'(busy0), 32'h0);
    chk("glitch_level", 32'(lvl0), 32'h1);

    // Channel 2 bounces with a 3-cycle period, then settles high
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      din[2] = (i % 3 != 2);
    end
    rises = 0;
    at    = 0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (rise0[2]) begin
        rises++;
        at = k;
      end
    end
    chk("bounce_rises", 32'(rises), 32'd1);
    chk("bounce_lat",   32'(at), 32'(ML + 2));

    // All channels change together
    din = '0;
    repeat (ML + 4) @(negedge clk);
    chk("all_clear", 32'(lvl0), 32'h0);
    din = 4'hF;
    repeat (ML + 2) @(negedge clk);
    chk("all_rise",  32'(rise0), 32'hF);
    chk("all_lvl1",  32'(lvl0),  32'hF);
    @(negedge clk);
    chk("all_rise_gone", 32'(rise0), 32'h0);
    din = 4'h0;
    repeat (ML + 2) @(negedge clk);
    chk("all_fall",  32'(fall0), 32'hF);
    chk("all_lvl0",  32'(lvl0),  32'h0);
    @(negedge clk);
    chk("all_fall_gone", 32'(fall0), 32'h0);

    // EN dropped at CNT=5 on channel 3, then restored: full restart
    din[3] = 1'b1;
    repeat (7) @(negedge clk);
    en = 1'b0;
    repeat (5) @(negedge clk);
    chk("en_off_busy",  32'(busy0), 32'h0);
    chk("en_off_level", 32'(lvl0),  32'h0);
    chk("en_off_rise",  32'(rise0), 32'h0);
    en = 1'b1;
    repeat (ML - 1) @(negedge clk);
    chk("en_restart_not_yet", 32'(lvl0), 32'h0);
    @(negedge clk);
    chk("en_restart_level", 32'(lvl0),  32'h8);
    chk("en_restart_rise",  32'(rise0), 32'h8);

    // Reset mid-check on the INIT_LVL=1 instance
    @(negedge clk);
    din = '0;
    #2 rst1 = 1'b1;
    @(negedge clk);
    #2 rst1 = 1'b0;
    repeat (5) @(negedge clk);
    chk("midrst_busy_before", 32'(busy1), 32'h1);
    #2 rst1 = 1'b1;
    #1;
    chk("midrst_level", 32'(lvl1),  32'hF);
    chk("midrst_busy",  32'(busy1), 32'h0);
    chk("midrst_fall",  32'(fall1), 32'h0);
    @(negedge clk);
    chk("midrst_fall_hold", 32'(fall1), 32'h0);
    #2 rst1 = 1'b0;
    repeat (ML + 6) @(negedge clk);

    // Randomized phase against the model
    rst_hold = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (rst_hold) begin
        #2 rst0 = 1'b0; rst1 = 1'b0;
        rst_hold = 1'b0;
      end else if ($urandom_range(399) == 0) begin
        #2 rst0 = 1'b1; rst1 = 1'b1;
        rst_hold = 1'b1;
      end
      for (int k = 0; k < N; k++)
        if ($urandom_range(9) == 0) din[k] = ~din[k];
      if (en && ($urandom_range(63) == 0)) en = 1'b0;
      else if (!en && ($urandom_range(5) == 0)) en = 1'b1;
    end
    rst0 = 1'b0;
    rst1 = 1'b0;
    repeat (5) @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
